// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one single-port memory, one transaction outstanding; grant c0, mem_req c1.., rvalid one cycle after mem_ack.
// Backpressure: requesters hold *_req until *_gnt; data wins collisions until the fetch has waited STARVE_MAX data grants.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t          state;
    logic [CW-1:0]   starve_cnt;
    logic            drop_flag;
    logic            starve_hit;
    logic            if_ok;

    assign starve_hit = (starve_cnt == CW'(STARVE_MAX));
    // A killed fetch is treated as not requesting, so the data port may take the slot.
    assign if_ok      = if_req && !if_kill;
    assign if_gnt     = !rst && (state == IDLE) && if_ok && (!dm_req || starve_hit);
    assign dm_gnt     = !rst && (state == IDLE) && dm_req && !if_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            drop_flag  <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            dm_rvalid  <= 1'b0;
            dm_rdata   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    drop_flag <= 1'b0;
                    if (if_gnt) begin
                        state      <= BUSY_I;
                        starve_cnt <= '0;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_be     <= 4'hF;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                    end else if (dm_gnt) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_be    <= dm_be;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        if (!if_req)
                            starve_cnt <= '0;
                        else if (!starve_hit)
                            starve_cnt <= starve_cnt + CW'(1);
                    end
                end
                BUSY_I: begin
                    if (if_kill)
                        drop_flag <= 1'b1;
                    if (mem_ack) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        drop_flag <= 1'b0;
                        // A kill in the ack cycle itself must also suppress the strobe.
                        if (!(drop_flag || if_kill)) begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        dm_rvalid <= 1'b1;
                        dm_rdata  <= mem_we ? 32'h0 : mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected read strobes are queued by the stimulus and checked by a monitor.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_kill, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] if_q[$];
    logic [31:0] dm_q[$];

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (if_rvalid) begin
            if (if_q.size() == 0) chk("if_rvalid_unexpected", 32'd1, 32'd0);
            else chk("if_rdata", if_rdata, if_q.pop_front());
        end
        if (dm_rvalid) begin
            if (dm_q.size() == 0) chk("dm_rvalid_unexpected", 32'd1, 32'd0);
            else chk("dm_rdata", dm_rdata, dm_q.pop_front());
        end
    end

    initial begin
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h0; if_kill = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h0; dm_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;

        // Reset: grants forced low, registered outputs cleared.
        tick(); sample();
        chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
        chk("rst_dm_gnt", {31'd0, dm_gnt}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        tick(); rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;

        // Single fetch, ack after 3 cycles.
        tick(); if_req = 1'b1; if_addr = 32'h100;
        sample(); chk("f_if_gnt_c0", {31'd0, if_gnt}, 32'd1);
        tick(); if_req = 1'b0;
        sample(); chk("f_mem_req_c1", {31'd0, mem_req}, 32'd1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_we_be", {27'd0, mem_we, mem_be}, 32'h0F);
        tick();
        sample(); chk("f_mem_req_c2", {31'd0, mem_req}, 32'd1);
        tick(); mem_ack = 1'b1; mem_rdata = 32'h00500093; if_q.push_back(32'h00500093);
        sample(); chk("f_mem_req_c3", {31'd0, mem_req}, 32'd1);
        tick(); mem_ack = 1'b0;
        sample(); chk("f_mem_req_c4", {31'd0, mem_req}, 32'd0);
        chk("f_if_rvalid_c4", {31'd0, if_rvalid}, 32'd1);

        // Collision: data first, fetch in the IDLE cycle after the data ack.
        tick(); if_req = 1'b1; if_addr = 32'h104; dm_req = 1'b1; dm_addr = 32'h200;
        sample(); chk("c_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        chk("c_if_gnt_c0", {31'd0, if_gnt}, 32'd0);
        tick(); dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h11112222; dm_q.push_back(32'h11112222);
        sample(); chk("c_if_gnt_busy", {31'd0, if_gnt}, 32'd0);
        chk("c_mem_addr_d", mem_addr, 32'h200);
        tick(); mem_ack = 1'b0;
        sample(); chk("c_if_gnt_idle", {31'd0, if_gnt}, 32'd1);
        tick(); if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h33334444; if_q.push_back(32'h33334444);
        sample(); chk("c_mem_addr_i", mem_addr, 32'h104);
        tick(); mem_ack = 1'b0;

        // Starvation: four data grants, then the fetch wins.
        dm_req = 1'b1; if_req = 1'b1; if_addr = 32'h300; dm_addr = 32'h400;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("s_dm_gnt", {31'd0, dm_gnt}, 32'd1);
            chk("s_if_gnt_low", {31'd0, if_gnt}, 32'd0);
            tick(); mem_ack = 1'b1; mem_rdata = 32'hC0DE0000 + i; dm_q.push_back(32'hC0DE0000 + i);
            tick(); mem_ack = 1'b0;
        end
        sample(); chk("s_if_gnt_5th", {31'd0, if_gnt}, 32'd1);
        chk("s_dm_gnt_5th", {31'd0, dm_gnt}, 32'd0);
        tick(); dm_req = 1'b0; if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000AAAA;
        if_q.push_back(32'h0000AAAA);
        sample(); chk("s_mem_addr_i", mem_addr, 32'h300);
        tick(); mem_ack = 1'b0;

        // Kill blocks a fetch grant in IDLE.
        if_req = 1'b1; if_kill = 1'b1; if_addr = 32'h500;
        sample(); chk("k_if_gnt_killed", {31'd0, if_gnt}, 32'd0);
        // Flush during BUSY_I: memory completes, no if_rvalid.
        tick(); if_kill = 1'b0;
        sample(); chk("k_if_gnt", {31'd0, if_gnt}, 32'd1);
        tick(); if_req = 1'b0; if_kill = 1'b1;
        tick(); if_kill = 1'b0;
        sample(); chk("k_mem_req_held", {31'd0, mem_req}, 32'd1);
        tick(); mem_ack = 1'b1; mem_rdata = 32'h00000BAD;
        tick(); mem_ack = 1'b0; dm_req = 1'b1; dm_addr = 32'h600;
        sample(); chk("k_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("k_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        tick(); dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000600D; dm_q.push_back(32'h0000600D);
        tick(); mem_ack = 1'b0;

        // Write with partial byte enables; captured fields held until ack.
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_wdata = 32'hDEADBEEF; dm_addr = 32'h700;
        sample(); chk("w_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        tick(); dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'hF; dm_wdata = 32'h0;
        sample(); chk("w_mem_we_be", {27'd0, mem_we, mem_be}, 32'h13);
        chk("w_mem_wdata_c1", mem_wdata, 32'hDEADBEEF);
        tick(); mem_ack = 1'b1; mem_rdata = 32'h12345678; dm_q.push_back(32'h0);
        sample(); chk("w_mem_wdata_c2", mem_wdata, 32'hDEADBEEF);
        tick(); mem_ack = 1'b0;

        // Reset in BUSY_D: abandoned, late ack ignored, IDLE takes a fetch.
        dm_req = 1'b1; dm_addr = 32'h800;
        sample(); chk("r_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        tick(); dm_req = 1'b0;
        tick(); rst = 1'b1;
        sample(); chk("r_mem_req_c2", {31'd0, mem_req}, 32'd1);
        tick(); rst = 1'b0;
        sample(); chk("r_mem_req_c3", {31'd0, mem_req}, 32'd0);
        tick(); mem_ack = 1'b1; mem_rdata = 32'h0000FFFF; if_req = 1'b1; if_addr = 32'h900;
        sample(); chk("r_if_gnt_c4", {31'd0, if_gnt}, 32'd1);
        tick(); mem_ack = 1'b0; if_req = 1'b0;
        sample(); chk("r_mem_addr", mem_addr, 32'h900);
        chk("r_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
        tick(); mem_ack = 1'b1; mem_rdata = 32'h00000077; if_q.push_back(32'h00000077);
        tick(); mem_ack = 1'b0;

        repeat (3) tick();
        chk("if_q_drained", if_q.size(), 32'd0);
        chk("dm_q_drained", dm_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
